// File: rtl/serial_mac_fir_filter_if.sv
// Port bundle of serial_mac_fir_filter: sample handshake, coefficient write port and result port.
// The source/controller side uses the master modport; the filter uses the slave modport.
interface serial_mac_fir_filter_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int AW     = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/serial_mac_fir_filter.sv
// Time-multiplexed FIR: one signed MAC walks TAPS run-time loadable coefficients per accepted sample.
// Define FIR_OUT_SAT_EN to saturate the rounded result to OUT_W bits; otherwise it wraps.
module serial_mac_fir_filter #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 51,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15,
    parameter int AW        = $clog2(TAPS)
) (
    input logic                   clk,
    input logic                   reset,
    serial_mac_fir_filter_if.slave bus
);
    localparam int              PROD_W     = DATA_W + COEF_W;
    localparam logic [AW-1:0]   LAST_K     = AW'(TAPS - 1);
    localparam logic [AW:0]     TAPS_EXT   = (AW + 1)'(TAPS);
    localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W + 1)'(1) <<< (OUT_SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic                     idle;
    logic                     accept;
    logic                     coef_wr_en;
    logic                     mac_en;
    logic                     out_load;

    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            wr_next;
    logic [AW-1:0]            k_cnt;
    logic [AW:0]              rd_diff;
    logic [AW-1:0]            rd_addr;

    logic signed [DATA_W-1:0] sample_mem [TAPS];
    logic signed [COEF_W-1:0] coef_mem   [TAPS];
    logic signed [DATA_W-1:0] rd_sample;
    logic signed [COEF_W-1:0] rd_coef;
    logic signed [PROD_W-1:0] prod;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    scaled;
    logic [OUT_W-1:0]         out_next;

    logic                     out_valid_q;
    logic [OUT_W-1:0]         out_data_q;

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk) begin
        // NOTE: registered state is always assigned non-blocking so every flop samples pre-edge values.
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned (latch).
        state_next = state;
        idle       = 1'b0;
        accept     = 1'b0;
        coef_wr_en = 1'b0;
        mac_en     = 1'b0;
        out_load   = 1'b0;
        case (state)
            S_IDLE: begin
                idle       = 1'b1;
                coef_wr_en = bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_EXT);
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (k_cnt == LAST_K) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                out_load   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.in_ready = idle;

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk) begin
        // NOTE: both arrays are cleared on reset because a zero history and zero taps are part of the reset state.
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                sample_mem[i] <= '0;
                coef_mem[i]   <= '0;
            end
        end else begin
            if (accept) begin
                sample_mem[wr_next] <= bus.in_data;
            end
            // A write in the accept cycle lands before k=0 reads it, so it applies to this sample.
            if (coef_wr_en) begin
                coef_mem[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    assign wr_next = (wr_ptr == LAST_K) ? '0 : wr_ptr + AW'(1);

    // x[n-k] lives at (wr_ptr - k) mod TAPS; borrow means add TAPS back.
    assign rd_diff   = {1'b0, wr_ptr} - {1'b0, k_cnt};
    assign rd_addr   = rd_diff[AW] ? AW'(rd_diff + TAPS_EXT) : rd_diff[AW-1:0];
    assign rd_sample = sample_mem[rd_addr];
    assign rd_coef   = coef_mem[k_cnt];
    assign prod      = PROD_W'(rd_sample) * PROD_W'(rd_coef);

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            k_cnt       <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_load;
            if (accept) begin
                wr_ptr <= wr_next;
                k_cnt  <= '0;
                acc    <= '0;
            end
            if (mac_en) begin
                acc   <= acc + ACC_W'(prod);
                k_cnt <= (k_cnt == LAST_K) ? '0 : k_cnt + AW'(1);
            end
            if (out_load) begin
                out_data_q <= out_next;
            end
        end
    end

    // Round half up, then arithmetic shift; one guard bit keeps the rounding add from overflowing.
    assign rnd_sum = (ACC_W + 1)'(acc) + ROUND_HALF;
    assign scaled  = rnd_sum >>> OUT_SHIFT;

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        if (scaled > SAT_MAX) begin
            out_next = OUT_W'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            out_next = OUT_W'(SAT_MIN);
        end else begin
            out_next = OUT_W'(scaled);
        end
    end
`else
    assign out_next = OUT_W'(scaled);
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_serial_mac_fir_filter.sv
// Self-checking bench for serial_mac_fir_filter (TAPS=4): directed spec scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a behavioural FIR model.
module tb_serial_mac_fir_filter;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int TAPS      = 4;
    localparam int ACC_W     = 40;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 15;
    localparam int AW        = $clog2(TAPS);

`ifdef FIR_OUT_SAT_EN
    localparam logic [OUT_W-1:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [OUT_W-1:0] SAT_EXP = 16'hFFF8;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_mac_fir_filter_if #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .AW(AW)
    ) bus ();

    serial_mac_fir_filter #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W),
        .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT), .AW(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    bit                        model_on = 1'b0;
    logic signed [DATA_W-1:0]  m_hist [TAPS];   // m_hist[k] = x[n-k]
    logic signed [COEF_W-1:0]  m_coef [TAPS];
    int                        m_remaining;
    logic [OUT_W-1:0]          m_pending;
    logic [OUT_W-1:0]          m_out_data;
    bit                        m_out_valid;
    bit                        m_in_ready;

    function automatic logic [OUT_W-1:0] ref_y(input longint acc);
        longint r;
        r = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
        if (r > 64'sd32767)  r = 64'sd32767;
        if (r < -64'sd32768) r = -64'sd32768;
`endif
        return OUT_W'(r);
    endfunction

    function automatic longint fir_sum();
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            s += longint'(m_coef[k]) * longint'(m_hist[k]);
        end
        return s;
    endfunction

    // Checks outputs mid-cycle, then advances the model over the coming rising edge.
    always @(negedge clk) begin : monitor
        bit was_idle;
        if (model_on) begin
            check("in_ready",  64'(bus.in_ready),  64'(m_in_ready));
            check("out_valid", 64'(bus.out_valid), 64'(m_out_valid));
            check("out_data",  64'(bus.out_data),  64'(m_out_data));
        end
        if (reset === 1'b0) begin
            model_on    = 1'b1;
            m_remaining = 0;
            m_out_valid = 1'b0;
            m_out_data  = '0;
            m_in_ready  = 1'b1;
            for (int k = 0; k < TAPS; k++) begin
                m_hist[k] = '0;
                m_coef[k] = '0;
            end
        end else if (model_on) begin
            was_idle    = (m_remaining == 0);
            m_out_valid = 1'b0;
            if (!was_idle) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_out_valid = 1'b1;
                    m_out_data  = m_pending;
                end
            end
            if (was_idle && bus.coef_we && int'(bus.coef_addr) < TAPS) begin
                m_coef[bus.coef_addr] = bus.coef_data;
            end
            if (was_idle && bus.in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0]   = bus.in_data;
                m_pending   = ref_y(fir_sum());
                m_remaining = TAPS + 1;
            end
            m_in_ready = (m_remaining == 0);
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        reset        = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic load_coef(input int k, input logic [COEF_W-1:0] v);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(k);
        bus.coef_data = v;
        tick();
        bus.coef_we = 1'b0;
    endtask

    task automatic load_impulse_coefs();
        load_coef(0, 16'h4000);
        load_coef(1, 16'h2000);
        load_coef(2, 16'h1000);
        load_coef(3, 16'h0800);
    endtask

    // Offers one sample, optionally with a coefficient write in the accept cycle or the first MAC cycle.
    task automatic send_sample(input logic [DATA_W-1:0] x, input bit cw_now, input bit cw_mac,
                               input logic [AW-1:0] ca, input logic [COEF_W-1:0] cd,
                               output logic [OUT_W-1:0] y, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        if (cw_now) begin
            bus.coef_we = 1'b1; bus.coef_addr = ca; bus.coef_data = cd;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (cw_mac) begin
            bus.coef_we = 1'b1; bus.coef_addr = ca; bus.coef_data = cd;
        end
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            bus.coef_we = 1'b0;
            lat++;
        end
        check("latency", 64'(lat), 64'(TAPS + 1));
        y = bus.out_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [OUT_W-1:0]  y;
        int                lat;
        logic [OUT_W-1:0]  imp_exp [5];
        logic [DATA_W-1:0] imp_in  [5];
        logic [DATA_W-1:0] data;
        int                cyc, last_acc, n_acc, pulses;
        bit                acc_now;

        imp_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        imp_exp = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0000};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state and model pins.
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("pin_impulse",    64'(ref_y(64'sh10000000)),         64'h2000);
        check("pin_sat",        64'(ref_y(64'sh00000000FFFC0004)), 64'(SAT_EXP));
        check("pin_half_neg",   64'(ref_y(-64'sd16384)),           64'h0000);
        check("pin_below_half", 64'(ref_y(-64'sd16385)),           64'hFFFF);

        // Impulse response.
        load_impulse_coefs();
        for (int i = 0; i < 5; i++) begin
            send_sample(imp_in[i], 1'b0, 1'b0, '0, '0, y, lat);
            check("impulse", 64'(y), 64'(imp_exp[i]));
        end

        // Saturation / wrap of a large positive sum.
        for (int k = 0; k < TAPS; k++) load_coef(k, 16'h7FFF);
        for (int i = 0; i < 4; i++) send_sample(16'h7FFF, 1'b0, 1'b0, '0, '0, y, lat);
        check("sat_4th", 64'(y), 64'(SAT_EXP));

        // Ring wrap: steady state once the history is full of impulses.
        load_impulse_coefs();
        for (int i = 0; i < 9; i++) begin
            send_sample(16'h4000, 1'b0, 1'b0, '0, '0, y, lat);
            if (i >= 3) check("ring_wrap", 64'(y), 64'h3C00);
        end

        // Coefficient write gating.
        apply_reset();
        load_impulse_coefs();
        send_sample(16'h4000, 1'b0, 1'b1, 2'd0, 16'h0000, y, lat);
        check("gate_mac_drop", 64'(y), 64'h2000);
        send_sample(16'h4000, 1'b1, 1'b0, 2'd0, 16'h0000, y, lat);
        check("gate_idle_apply", 64'(y), 64'h1000);

        // Reset in the middle of a MAC run.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data",  64'(bus.out_data),  64'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(bus.out_valid);
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);
        load_impulse_coefs();
        for (int i = 0; i < 5; i++) begin
            send_sample(imp_in[i], 1'b0, 1'b0, '0, '0, y, lat);
            check("post_rst_impulse", 64'(y), 64'(imp_exp[i]));
        end

        // Back-pressure: in_valid held high, data advances only on accept.
        data         = 16'h0100;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        cyc = 0; last_acc = -1; n_acc = 0;
        for (int i = 0; i < 6 * 10 + 2; i++) begin
            acc_now = bus.in_ready;
            tick();
            cyc++;
            if (acc_now) begin
                if (last_acc >= 0) check("bp_gap", 64'(cyc - last_acc), 64'(TAPS + 2));
                last_acc = cyc;
                n_acc++;
                data++;
                bus.in_data = data;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", 64'(n_acc), 64'd11);
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic with random coefficient writes and one reset.
        for (int k = 0; k < TAPS; k++) load_coef(k, COEF_W'($urandom));
        for (int i = 0; i < 600; i++) begin
            if (!bus.in_valid && $urandom_range(3) == 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DATA_W'($urandom);
            end
            bus.coef_we   = ($urandom_range(7) == 0);
            bus.coef_addr = AW'($urandom);
            bus.coef_data = COEF_W'($urandom);
            reset         = (i == 300) ? 1'b0 : 1'b1;
            acc_now       = bus.in_valid && bus.in_ready && reset;
            tick();
            if (acc_now) bus.in_valid = 1'b0;
        end
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mac_fir_filter.md
# serial_mac_fir_filter

Parametrised, time-multiplexed FIR filter: one signed multiply-accumulate unit iterates over TAPS coefficients per input sample, replacing the fully parallel one-multiplier-per-tap structure in the FIR filter family. Coefficients are run-time loadable through a write port. The input uses a valid/ready handshake, so upstream sample sources stall while a result is computed. Output is rounded and scaled from the accumulator, with optional saturation.

## Interface
- DATA_W, 16: input sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed Q1.(COEF_W-1).
- TAPS, 51: number of taps, 2..256.
- ACC_W, 40: accumulator width, signed; must be ≥ DATA_W+COEF_W+$clog2(TAPS).
- OUT_W, 16: output width, signed.
- OUT_SHIFT, 15: right shift applied to the accumulator before output, 1..ACC_W-OUT_W.
- AW, $clog2(TAPS): coefficient address width (derived).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  sample x[n].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  tap index k.
- coef_data  in  COEF_W  value of b[k].
- out_valid  out  1  one-cycle pulse, out_data updated.
- out_data  out  OUT_W  y[n], held until the next result.

## Operation
- Storage: sample ring buffer of TAPS×DATA_W with write pointer wr_ptr; coefficient array of TAPS×COEF_W.
- The sum is y[n] = Σ b[k]·x[n−k] for k = 0..TAPS−1. Sample x[n−k] is read at address (wr_ptr − k) mod TAPS.
- States:
  - IDLE: in_ready=1. When in_valid && in_ready, write in_data at the next wr_ptr slot, clear acc, set k=0, and go to MAC.
  - MAC: in_ready=0. Each cycle acc += b[k]·x[n−k] as a full-precision product, sign-extended to ACC_W. Then k++. After k=TAPS−1, go to OUT.
  - OUT: load out_data, pulse out_valid, and return to IDLE.
- wr_ptr wraps from TAPS−1 to 0.
- Scaling: r = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT. This is arithmetic shift, round-half-up. r is then reduced to OUT_W bits (see Configuration).
- Coefficient writes:
  - Applied only in IDLE. coef_we in MAC or OUT is dropped.
  - coef_addr ≥ TAPS is ignored.
  - A write in the same IDLE cycle as a sample accept takes effect for that sample.
- in_valid while in_ready=0 is not accepted. The source holds the sample, and no data is lost.
- Reset (reset=0 at an edge), including mid-MAC:
  - state=IDLE, wr_ptr=0, k=0, acc=0.
  - Sample buffer and coefficients are cleared to 0.
  - out_valid=0, out_data=0, in_ready=1 in the cycle after reset deasserts.

## Timing
- Sample accepted at edge E0 → out_valid high during the cycle after edge E0+TAPS+1. Latency is TAPS+1 clocks.
- in_ready is low from E0 until it returns high in the same cycle as out_valid. The next sample can be accepted at that edge.
- Maximum throughput is one sample per TAPS+2 clocks.
- out_valid is exactly one cycle wide. out_data changes only with out_valid.
- Multiplier and adder are single-cycle. An implementation may add one product register only if the TAPS+1 latency is preserved by overlapping the final add with OUT.

## Configuration
- FIR_OUT_SAT_EN defined:
  - r > 2^(OUT_W−1)−1 → out_data = 2^(OUT_W−1)−1.
  - r < −2^(OUT_W−1) → out_data = −2^(OUT_W−1).
- FIR_OUT_SAT_EN undefined: out_data = r[OUT_W−1:0], two's-complement wrap. No saturation logic is instantiated.

## Test plan
All scenarios use TAPS=4, defaults otherwise.
- Impulse response:
  - Stimulus: coefficients {0x4000, 0x2000, 0x1000, 0x0800}; inputs 0x4000, 0, 0, 0, 0.
  - Required: out_data 0x2000, 0x1000, 0x0800, 0x0400, 0x0000.
  - Each out_valid occurs 5 clocks after its accept.
- Saturation:
  - Stimulus: all coefficients 0x7FFF; input 0x7FFF four times.
  - Required: 4th output 0x7FFF with FIR_OUT_SAT_EN defined; 0xFFF8 without it (acc = 0xFFFC0004).
- Back-pressure:
  - Stimulus: in_valid held high continuously with incrementing data.
  - Required: exactly one accept per 6 clocks; in_ready low during MAC; no sample skipped or duplicated.
- Coefficient write gating:
  - Stimulus: coef_we to tap 0 during MAC.
  - Required: write dropped and the current output unchanged.
  - Stimulus: the same write in IDLE coincident with an accept.
  - Required: the new value is used for that output.
- Reset mid-operation:
  - Stimulus: reset low for one cycle during MAC.
  - Required: out_valid never pulses for the aborted sample; out_data=0; in_ready=1 next cycle.
  - Stimulus: after reloading coefficients, a subsequent impulse.
  - Required: it reproduces the impulse-response sequence.
- Ring wrap:
  - Stimulus: 9 consecutive impulses at 0x4000.
  - Required: steady output 0x3C00 from the 4th result onward.
